// File: rtl/cm_pkg.sv
// cm_pkg: shared defaults, FSM states and FIFO entry layout for the merge sink
package cm_pkg;
  localparam int DW_DEF = 8;
  localparam int DEPTH_DEF = 4;
  typedef enum logic [1:0] {RESYNC, IDLE, ACK} state_t;
  typedef struct packed {
    logic              src;
    logic [DW_DEF-1:0] data;
  } entry_t;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for a single asynchronous bit
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk)
    if (rst) {q, m} <= 2'b00;
    else     {q, m} <= {m, d};
endmodule

// File: rtl/cm_sink.sv
// cm_sink: 4-phase handshake receiver from a merge element feeding a small valid/ready FIFO
module cm_sink
  import cm_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     CP,
  input  logic                     MR,
  input  logic                     Send_in,
  output logic                     Ack_out,
  input  logic [DW-1:0]            Data_in,
  input  logic                     Src_in,
  output logic                     Out_valid,
  input  logic                     Out_ready,
  output logic [DW-1:0]            Out_data,
  output logic                     Out_src,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Full
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic          src;
    logic [DW-1:0] data;
  } slot_t;
  slot_t          mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic           sreq, push, pop;
  logic [1:0]     warm;
  state_t         state, state_n;
  sync2 u_sync (.clk(CP), .rst(MR), .d(Send_in), .q(sreq));
  assign Out_valid = Count != '0;
  assign Full      = Count == (AW+1)'(DEPTH);
  assign pop       = Out_valid & Out_ready;
  assign Out_data  = mem[rptr].data;
  assign Out_src   = mem[rptr].src;
  // warm fills once the synchronizer carries post-reset samples, so a request held across reset is not mistaken for idle
  always_ff @(posedge CP)
    if (MR) begin
      state   <= RESYNC;
      warm    <= 2'b00;
      Ack_out <= 1'b0;
    end else begin
      state   <= state_n;
      warm    <= {warm[0], 1'b1};
      Ack_out <= state_n == ACK;
    end
  always_comb begin
    state_n = state == RESYNC ? ((warm[1] && !sreq) ? IDLE : RESYNC)
            : state == IDLE   ? (push ? ACK : IDLE)
            :                   (sreq ? ACK : IDLE);
  end
  always_comb begin
    push = state == IDLE && sreq && (!Full || pop);
  end
  always_ff @(posedge CP)
    if (push) mem[wptr] <= '{src: Src_in, data: Data_in};
  always_ff @(posedge CP)
    if (MR) begin
      wptr  <= '0;
      rptr  <= '0;
      Count <= '0;
    end else begin
      wptr  <= wptr + AW'(push);
      rptr  <= rptr + AW'(pop);
      Count <= Count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: tb/tb_cm_sink.sv
// tb_cm_sink: directed and randomized checks of cm_sink against a token-queue model
module tb_cm_sink;
  import cm_pkg::*;
  localparam int DW = DW_DEF;
  localparam int DEPTH = DEPTH_DEF;
  logic clk = 0, mr = 1, send = 0, ready = 0, src = 0;
  logic [DW-1:0] data = '0;
  logic ack, valid, osrc, full;
  logic [DW-1:0] odata;
  logic [$clog2(DEPTH):0] count;
  bit ready_fix = 0, rnd_ready = 0, track = 0;
  int vectors = 0, errors = 0, peak = 0;
  entry_t model_q[$];
  logic popped_src[$];
  logic prev_ack = 0;
  cm_sink #(.DW(DW), .DEPTH(DEPTH)) dut (
    .CP(clk), .MR(mr), .Send_in(send), .Ack_out(ack), .Data_in(data), .Src_in(src),
    .Out_valid(valid), .Out_ready(ready), .Out_data(odata), .Out_src(osrc),
    .Count(count), .Full(full)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_ack(logic v, string tag);
    int i = 0;
    while (ack !== v && i < 60) begin
      tick();
      i++;
    end
    check(tag, ack, v);
  endtask
  task automatic send_tok(logic [DW-1:0] d, logic s);
    data = d;
    src = s;
    send = 1;
    wait_ack(1, "ack_rise");
    send = 0;
    wait_ack(0, "ack_fall");
  endtask
  task automatic drain();
    int i = 0;
    ready_fix = 1;
    while (count != 0 && i < 200) begin
      tick();
      i++;
    end
    tick(2);
    check("drain", count, 0);
    ready_fix = 0;
    tick(2);
  endtask
  initial forever begin
    @(posedge clk);
    #2;
    ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_fix;
  end
  // model: a token enters when its acknowledge rises, leaves when the consumer takes the head
  always @(negedge clk) begin
    if (mr) begin
      model_q.delete();
      prev_ack = 0;
    end else begin
      if (ack && !prev_ack) begin
        check("ack_room", model_q.size() < DEPTH, 1);
        model_q.push_back('{src: src, data: data});
      end
      prev_ack = ack;
      check("count", count, model_q.size());
      check("full", full, model_q.size() == DEPTH);
      check("valid", valid, model_q.size() != 0);
      if (model_q.size() != 0) begin
        check("head_data", odata, model_q[0].data);
        check("head_src", osrc, model_q[0].src);
      end
      peak = track ? (int'(count) > peak ? int'(count) : peak) : 0;
      if (valid && ready && model_q.size() != 0) begin
        popped_src.push_back(osrc);
        void'(model_q.pop_front());
      end
    end
  end
  initial begin
    int base;
    tick(3);
    mr = 0;
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_valid", valid, 0);
    check("rst_ack", ack, 0);
    tick(5);
    data = 8'h5A;
    src = 1;
    send = 1;
    tick(2);
    check("lat_early", ack, 0);
    tick();
    check("lat_ack", ack, 1);
    check("lat_data", odata, 8'h5A);
    check("lat_src", osrc, 1);
    check("lat_count", count, 1);
    send = 0;
    tick(2);
    check("fall_early", ack, 1);
    tick();
    check("fall_ack", ack, 0);
    drain();
    for (int i = 1; i <= 4; i++) send_tok(DW'(i), 0);
    check("fill_full", full, 1);
    check("fill_count", count, 4);
    data = 8'h05;
    src = 0;
    send = 1;
    tick(8);
    check("bp_ack", ack, 0);
    check("bp_count", count, 4);
    ready_fix = 1;
    tick();
    ready_fix = 0;
    check("simul_ack", ack, 1);
    check("simul_count", count, 4);
    check("simul_head", odata, 8'h02);
    send = 0;
    wait_ack(0, "simul_fall");
    drain();
    ready_fix = 1;
    track = 1;
    tick(2);
    for (int i = 0; i < 10; i++) send_tok(DW'(8'h10 + i), 0);
    tick(4);
    check("wrap_peak", peak <= 2, 1);
    check("wrap_empty", count, 0);
    track = 0;
    ready_fix = 0;
    tick(2);
    send_tok(8'h31, 0);
    send_tok(8'h32, 1);
    data = 8'h33;
    src = 0;
    send = 1;
    wait_ack(1, "mid_ack");
    check("mid_count", count, 3);
    mr = 1;
    tick();
    mr = 0;
    check("mr_count", count, 0);
    check("mr_ack", ack, 0);
    check("mr_valid", valid, 0);
    tick(10);
    check("absorb_ack", ack, 0);
    check("absorb_count", count, 0);
    send = 0;
    tick(5);
    send_tok(8'h77, 1);
    check("reaccept_count", count, 1);
    drain();
    base = popped_src.size();
    for (int i = 0; i < 4; i++) send_tok(DW'(8'hA0 + i), i % 2 == 0);
    drain();
    check("tag_n", popped_src.size() - base, 4);
    if (popped_src.size() >= base + 4)
      for (int i = 0; i < 4; i++) check("tag_seq", popped_src[base+i], i % 2 == 0);
    rnd_ready = 1;
    for (int i = 0; i < 60; i++) begin
      send_tok(DW'($urandom), 1'($urandom_range(0, 1)));
      tick($urandom_range(0, 3));
    end
    rnd_ready = 0;
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
